// File: rtl/door_button_conditioner.sv
// Button front-end for DoorLock: synchronise, debounce and turn raw buttons into single-cycle events.
// Optional digit autorepeat is enabled by defining DIGIT_AUTOREPEAT_EN.
module door_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned LONG_CYCLES     = 64,
  parameter int unsigned REPEAT_CYCLES   = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [9:0] digit_buttons,
  input  logic       confirm_button,
  input  logic       shuffle_button,
  output logic       digit_valid,
  output logic [3:0] digit_value,
  output logic       digit_error,
  output logic       confirm_short,
  output logic       confirm_long,
  output logic       shuffle_pulse,
  output logic       any_pressed
);

  localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  typedef enum logic {D_IDLE, D_HELD} dstate_t;
  typedef enum logic [1:0] {C_IDLE, C_COUNT, C_LONG} cstate_t;

  logic [11:0]    raw;
  logic [11:0]    sync1_q, sync2_q;
  logic [11:0]    deb_q, deb_d, deb_prev_q;
  logic [DBW-1:0] dbc_q [12];
  logic [DBW-1:0] dbc_d [12];

  dstate_t        dstate_q, dstate_d;
  cstate_t        cstate_q, cstate_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dv_q, dv_d, derr_q, derr_d;
  logic [3:0]     dval_q, dval_d;
  logic           short_q, short_d, long_q, long_d, shuf_q, shuf_d;

  logic [9:0]     dig_rise, dig_lvl;
  logic           conf_rise, conf_fall, shuf_rise;

  assign raw = {shuffle_button, confirm_button, digit_buttons};

  // Bits 9:0 digits, bit 10 confirm, bit 11 shuffle.
  assign dig_rise  = deb_q[9:0] & ~deb_prev_q[9:0];
  assign dig_lvl   = deb_q[9:0];
  assign conf_rise = deb_q[10] & ~deb_prev_q[10];
  assign conf_fall = ~deb_q[10] & deb_prev_q[10];
  assign shuf_rise = deb_q[11] & ~deb_prev_q[11];

  function automatic logic is_onehot(input logic [9:0] x);
    return (x != '0) && ((x & (x - 10'd1)) == '0);
  endfunction

  function automatic logic [3:0] encode(input logic [9:0] x);
    logic [3:0] v;
    v = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (x[i]) v = 4'(i);
    end
    return v;
  endfunction

  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < 12; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dbc_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
        else                     dbc_d[i] = dbc_q[i] + 1'b1;
      end
    end
  end

`ifdef DIGIT_AUTOREPEAT_EN
  localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_q, rpt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`endif

  always_comb begin
    dstate_d = dstate_q;
    dv_d     = 1'b0;
    dval_d   = '0;
    derr_d   = 1'b0;
`ifdef DIGIT_AUTOREPEAT_EN
    rpt_d    = rpt_q;
`endif
    case (dstate_q)
      D_IDLE: begin
`ifdef DIGIT_AUTOREPEAT_EN
        rpt_d = '0;
`endif
        if (dig_rise != '0) begin
          dstate_d = D_HELD;
          if (is_onehot(dig_rise)) begin
            dv_d   = 1'b1;
            dval_d = encode(dig_rise);
          end else begin
            derr_d = 1'b1;
          end
        end
      end
      default: begin
        if (dig_lvl == '0) dstate_d = D_IDLE;
`ifdef DIGIT_AUTOREPEAT_EN
        // Repeat timer only runs while a single digit is held; any other level restarts it.
        if (is_onehot(dig_lvl)) begin
          if (rpt_q == RP_LAST) begin
            rpt_d  = '0;
            dv_d   = 1'b1;
            dval_d = encode(dig_lvl);
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end else begin
          rpt_d = '0;
        end
`endif
      end
    endcase
  end

  always_comb begin
    cstate_d = cstate_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    shuf_d   = shuf_rise;
    case (cstate_q)
      C_IDLE: begin
        if (conf_rise) begin
          cstate_d = C_COUNT;
          cnt_d    = '0;
        end
      end
      C_COUNT: begin
        if (conf_fall) begin
          short_d  = 1'b1;
          cstate_d = C_IDLE;
        end else begin
          if (cnt_q != LONG_LAST) cnt_d = cnt_q + 1'b1;
          if (cnt_d == LONG_LAST) begin
            long_d   = 1'b1;
            cstate_d = C_LONG;
          end
        end
      end
      C_LONG: begin
        if (conf_fall) cstate_d = C_IDLE;
      end
      default: cstate_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int unsigned i = 0; i < 12; i++) dbc_q[i] <= '0;
      dstate_q   <= D_IDLE;
      cstate_q   <= C_IDLE;
      cnt_q      <= '0;
      dv_q       <= 1'b0;
      dval_q     <= '0;
      derr_q     <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      shuf_q     <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int unsigned i = 0; i < 12; i++) dbc_q[i] <= dbc_d[i];
      dstate_q   <= dstate_d;
      cstate_q   <= cstate_d;
      cnt_q      <= cnt_d;
      dv_q       <= dv_d;
      dval_q     <= dval_d;
      derr_q     <= derr_d;
      short_q    <= short_d;
      long_q     <= long_d;
      shuf_q     <= shuf_d;
    end
  end

  assign digit_valid   = dv_q;
  assign digit_value   = dval_q;
  assign digit_error   = derr_q;
  assign confirm_short = short_q;
  assign confirm_long  = long_q;
  assign shuffle_pulse = shuf_q;
  assign any_pressed   = |deb_q;

endmodule

// File: tb/tb_door_button_conditioner.sv
// Directed bench for door_button_conditioner (10 ns clock, default parameters).
module tb_door_button_conditioner;

  logic       clk = 1'b0;
  logic       rstn;
  logic [9:0] digit_buttons;
  logic       confirm_button, shuffle_button;
  logic       digit_valid, digit_error, confirm_short, confirm_long, shuffle_pulse, any_pressed;
  logic [3:0] digit_value;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int n_dv, n_err, n_short, n_long, n_shuf, bad_val, both_conf, any_seen;
  int last_dv_cyc, last_dv_val, last_short_cyc, last_long_cyc, last_shuf_cyc;

  door_button_conditioner #(
    .DEBOUNCE_CYCLES(3),
    .LONG_CYCLES(64),
    .REPEAT_CYCLES(32)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .digit_buttons(digit_buttons),
    .confirm_button(confirm_button),
    .shuffle_button(shuffle_button),
    .digit_valid(digit_valid),
    .digit_value(digit_value),
    .digit_error(digit_error),
    .confirm_short(confirm_short),
    .confirm_long(confirm_long),
    .shuffle_pulse(shuffle_pulse),
    .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: sampled 1 ns after each rising edge; cyc is then the index of that edge.
  always @(posedge clk) begin
    #1;
    if (digit_valid) begin
      n_dv++;
      last_dv_cyc = cyc;
      last_dv_val = int'(digit_value);
    end else if (digit_value != 4'd0) begin
      bad_val++;
    end
    if (digit_error)   n_err++;
    if (confirm_short) begin n_short++; last_short_cyc = cyc; end
    if (confirm_long)  begin n_long++;  last_long_cyc  = cyc; end
    if (confirm_short && confirm_long) both_conf++;
    if (shuffle_pulse) begin n_shuf++; last_shuf_cyc = cyc; end
    if (any_pressed) any_seen = 1;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    n_dv = 0; n_err = 0; n_short = 0; n_long = 0; n_shuf = 0;
    bad_val = 0; both_conf = 0; any_seen = 0;
    last_dv_cyc = -1; last_dv_val = -1; last_short_cyc = -1;
    last_long_cyc = -1; last_shuf_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    digit_buttons = '1;
    confirm_button = 1'b1;
    shuffle_button = 1'b1;
    clear_counts();
    idle(4);
    checks++;
    if ({digit_valid, digit_value, digit_error, confirm_short, confirm_long, shuffle_pulse, any_pressed} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0",
               {digit_valid, digit_value, digit_error, confirm_short, confirm_long, shuffle_pulse, any_pressed});
    end
    digit_buttons = '0;
    confirm_button = 1'b0;
    shuffle_button = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(10);
    checks++;
    if (n_dv + n_err + n_short + n_long + n_shuf + any_seen != 0) begin
      errors++;
      $display("FAIL reset_quiet: got %0d events expected 0", n_dv + n_err + n_short + n_long + n_shuf + any_seen);
    end
  endtask

  task automatic test_digit_press();
    int n0;
    @(negedge clk);
    clear_counts();
    n0 = cyc + 1;
    digit_buttons = 10'd1 << 6;
    idle(5);
    checks++;
    if (any_pressed !== 1'b1) begin errors++; $display("FAIL d6_any_pressed: got %b expected 1", any_pressed); end
    digit_buttons = '0;
    idle(15);
    checks++;
    if (n_dv != 1) begin errors++; $display("FAIL d6_count: got %0d expected 1", n_dv); end
    checks++;
    if (last_dv_val != 6) begin errors++; $display("FAIL d6_value: got %0d expected 6", last_dv_val); end
    checks++;
    if (last_dv_cyc != n0 + 5) begin errors++; $display("FAIL d6_latency: got %0d expected %0d", last_dv_cyc, n0 + 5); end
    checks++;
    if (n_err + n_short + n_long + n_shuf + bad_val != 0) begin
      errors++; $display("FAIL d6_other_pulses: got %0d expected 0", n_err + n_short + n_long + n_shuf + bad_val);
    end
    checks++;
    if (any_pressed !== 1'b0) begin errors++; $display("FAIL d6_released: got %b expected 0", any_pressed); end
  endtask

  task automatic test_debounce_boundary();
    int n0;
    @(negedge clk);
    clear_counts();
    digit_buttons = 10'd1 << 9;
    idle(2);
    digit_buttons = '0;
    idle(15);
    checks++;
    if (n_dv != 0) begin errors++; $display("FAIL glitch_dv: got %0d expected 0", n_dv); end
    checks++;
    if (any_seen != 0) begin errors++; $display("FAIL glitch_any: got %0d expected 0", any_seen); end
    clear_counts();
    n0 = cyc + 1;
    digit_buttons = 10'd1 << 3;
    idle(3);
    digit_buttons = '0;
    idle(15);
    checks++;
    if (n_dv != 1 || last_dv_val != 3 || last_dv_cyc != n0 + 5) begin
      errors++;
      $display("FAIL three_cycle_press: got count %0d value %0d cycle %0d expected 1 3 %0d",
               n_dv, last_dv_val, last_dv_cyc, n0 + 5);
    end
  endtask

  task automatic test_multi_digit();
    @(negedge clk);
    clear_counts();
    digit_buttons = (10'd1 << 6) | (10'd1 << 8);
    idle(6);
    digit_buttons = '0;
    idle(15);
    checks++;
    if (n_err != 1) begin errors++; $display("FAIL multi_error: got %0d expected 1", n_err); end
    checks++;
    if (n_dv != 0) begin errors++; $display("FAIL multi_valid: got %0d expected 0", n_dv); end
    clear_counts();
    digit_buttons = 10'd1 << 8;
    idle(5);
    digit_buttons = '0;
    idle(15);
    checks++;
    if (n_dv != 1 || last_dv_val != 8 || n_err != 0) begin
      errors++;
      $display("FAIL after_multi: got count %0d value %0d err %0d expected 1 8 0", n_dv, last_dv_val, n_err);
    end
  endtask

  task automatic test_confirm_short();
    int n0;
    @(negedge clk);
    clear_counts();
    n0 = cyc + 1;
    confirm_button = 1'b1;
    idle(30);
    confirm_button = 1'b0;
    idle(20);
    checks++;
    if (n_short != 1) begin errors++; $display("FAIL short_count: got %0d expected 1", n_short); end
    checks++;
    if (last_short_cyc != n0 + 35) begin errors++; $display("FAIL short_latency: got %0d expected %0d", last_short_cyc, n0 + 35); end
    checks++;
    if (n_long != 0) begin errors++; $display("FAIL short_no_long: got %0d expected 0", n_long); end
  endtask

  task automatic test_confirm_long();
    int n0;
    @(negedge clk);
    clear_counts();
    n0 = cyc + 1;
    confirm_button = 1'b1;
    idle(100);
    confirm_button = 1'b0;
    idle(20);
    checks++;
    if (n_long != 1) begin errors++; $display("FAIL long_count: got %0d expected 1", n_long); end
    checks++;
    if (last_long_cyc != n0 + 68) begin errors++; $display("FAIL long_latency: got %0d expected %0d", last_long_cyc, n0 + 68); end
    checks++;
    if (n_short != 0 || both_conf != 0) begin
      errors++; $display("FAIL long_no_short: got short %0d both %0d expected 0 0", n_short, both_conf);
    end
  endtask

  task automatic test_shuffle_concurrent();
    int n0;
    @(negedge clk);
    clear_counts();
    n0 = cyc + 1;
    shuffle_button = 1'b1;
    digit_buttons = 10'd1 << 2;
    idle(5);
    digit_buttons = '0;
    idle(45);
    shuffle_button = 1'b0;
    idle(20);
    checks++;
    if (n_shuf != 1 || last_shuf_cyc != n0 + 5) begin
      errors++; $display("FAIL shuffle_pulse: got count %0d cycle %0d expected 1 %0d", n_shuf, last_shuf_cyc, n0 + 5);
    end
    checks++;
    if (n_dv != 1 || last_dv_val != 2 || last_dv_cyc != n0 + 5) begin
      errors++;
      $display("FAIL concurrent_digit: got count %0d value %0d cycle %0d expected 1 2 %0d",
               n_dv, last_dv_val, last_dv_cyc, n0 + 5);
    end
  endtask

  task automatic test_reset_mid_press();
    @(negedge clk);
    clear_counts();
    confirm_button = 1'b1;
    idle(37);
    rstn = 1'b0;
    idle(1);
    checks++;
    if ({any_pressed, confirm_short, confirm_long} !== 3'b000) begin
      errors++; $display("FAIL midreset_outputs: got %b expected 000", {any_pressed, confirm_short, confirm_long});
    end
    idle(1);
    confirm_button = 1'b0;
    idle(1);
    rstn = 1'b1;
    any_seen = 0;
    idle(30);
    checks++;
    if (n_short != 0 || n_long != 0) begin
      errors++; $display("FAIL midreset_no_pulse: got short %0d long %0d expected 0 0", n_short, n_long);
    end
    checks++;
    if (any_seen != 0) begin errors++; $display("FAIL midreset_any: got %0d expected 0", any_seen); end
  endtask

  task automatic test_autorepeat();
    int n0;
    int exp_n;
    int exp_last;
    @(negedge clk);
    clear_counts();
    n0 = cyc + 1;
`ifdef DIGIT_AUTOREPEAT_EN
    exp_n = 4;
    exp_last = n0 + 101;
`else
    exp_n = 1;
    exp_last = n0 + 5;
`endif
    digit_buttons = 10'd1;
    idle(100);
    digit_buttons = '0;
    idle(20);
    checks++;
    if (n_dv != exp_n) begin errors++; $display("FAIL hold_count: got %0d expected %0d", n_dv, exp_n); end
    checks++;
    if (last_dv_cyc != exp_last || last_dv_val != 0 || bad_val != 0) begin
      errors++;
      $display("FAIL hold_last: got cycle %0d value %0d badval %0d expected %0d 0 0",
               last_dv_cyc, last_dv_val, bad_val, exp_last);
    end
  endtask

  initial begin
    test_reset();
    test_digit_press();
    test_debounce_boundary();
    test_multi_digit();
    test_confirm_short();
    test_confirm_long();
    test_shuffle_concurrent();
    test_reset_mid_press();
    test_autorepeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
